vga_sync_gen: RTL and testbench

640x480 @ 60 Hz VGA timing generator for the text-mode display path. It divides the system clock into a pixel tick and produces registered horizontal and vertical sync pulses. It also supplies the current pixel coordinates and a visible-area flag. Downstream character-grid and font-lookup logic uses `x`/`y` to select the glyph row and column and `video_on` to blank the colour outputs.

---
 rtl/vga_sync_gen.sv | 101 ++++++++++
 tb/tb_vga_sync_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// VGA raster timing generator (640x480 @ 60 Hz with default parameters).
// Divides the system clock down to a pixel tick, runs the horizontal and
// vertical pixel counters, and produces registered active-low sync pulses,
// the current pixel coordinates and a visible-area flag.
//
// Ports:
//   clk      in   system clock, all state changes on its rising edge
//   reset    in   asynchronous, active-high reset
//   hsync    out  horizontal sync, active low (registered)
//   vsync    out  vertical sync, active low (registered)
//   video_on out  high while (x,y) lies in the visible area
//   p_tick   out  high on the clk cycle at whose end the counters advance
//   x        out  current horizontal pixel count (10 bits)
//   y        out  current line count (10 bits)
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        // Sync registers decode the next counter values so they switch on
        // the same edge as x/y.
        hsync_d = !((h_d >= HS_START) && (h_d < HS_END));
        vsync_d = !((v_d >= VS_START) && (v_d < VS_END));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign p_tick   = tick;
    assign x        = h_q;
    assign y        = v_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: one instance with the default 640x480 timing
// and one with a shrunken raster (24x12 pixels) so whole frames fit in a
// short run. Both are checked every cycle against a raster model that
// derives the expected outputs from the number of clk edges since reset.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       hs_d, vs_d, von_d, pt_d;
    logic [9:0] x_d, y_d;
    logic       hs_s, vs_s, von_s, pt_s;
    logic [9:0] x_s, y_s;

    vga_sync_gen dut_def (
        .clk(clk), .reset(reset), .hsync(hs_d), .vsync(vs_d),
        .video_on(von_d), .p_tick(pt_d), .x(x_d), .y(y_d)
    );

    vga_sync_gen #(
        .CLK_DIV(4), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut_small (
        .clk(clk), .reset(reset), .hsync(hs_s), .vsync(vs_s),
        .video_on(von_s), .p_tick(pt_s), .x(x_s), .y(y_s)
    );

    int nvec = 0;
    int nerr = 0;
    int k = 0;      // rising clk edges since reset was last asserted
    bit run = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
    } exp_t;

    // Raster position follows directly from elapsed edges: pixel index is
    // edges / CLK_DIV, wrapped over the line and frame lengths.
    function automatic exp_t model(int kk, int cd, int hd, int hf, int hsw,
                                   int hb, int vd, int vf, int vsw, int vb);
        exp_t e;
        int ht, vt, p, h, v;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        p  = kk / cd;
        h  = p % ht;
        v  = (p / ht) % vt;
        e.x   = 10'(h);
        e.y   = 10'(v);
        e.pt  = ((kk % cd) == cd - 1);
        e.hs  = !(h >= hd + hf && h < hd + hf + hsw);
        e.vs  = !(v >= vd + vf && v < vd + vf + vsw);
        e.von = (h < hd) && (v < vd);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at k=%0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            exp_t ed, es;
            ed = model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
            es = model(k, 4, 16, 2, 3, 3, 6, 2, 2, 2);
            chk("def.x", x_d, ed.x);      chk("def.y", y_d, ed.y);
            chk("def.hsync", hs_d, ed.hs); chk("def.vsync", vs_d, ed.vs);
            chk("def.video_on", von_d, ed.von); chk("def.p_tick", pt_d, ed.pt);
            chk("sm.x", x_s, es.x);       chk("sm.y", y_s, es.y);
            chk("sm.hsync", hs_s, es.hs);  chk("sm.vsync", vs_s, es.vs);
            chk("sm.video_on", von_s, es.von); chk("sm.p_tick", pt_s, es.pt);
        end
    end

    task automatic at_k(input int t);
        int g = 0;
        while (k != t && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (k != t) begin
            nvec++;
            nerr++;
            $display("FAIL timeout waiting for k=%0d: got k=%0d", t, k);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst.def.x", x_d, 0);        chk("rst.def.y", y_d, 0);
        chk("rst.def.hsync", hs_d, 1);   chk("rst.def.vsync", vs_d, 1);
        chk("rst.def.video_on", von_d, 1); chk("rst.def.p_tick", pt_d, 0);
        chk("rst.sm.x", x_s, 0);         chk("rst.sm.y", y_s, 0);
        chk("rst.sm.hsync", hs_s, 1);    chk("rst.sm.vsync", vs_s, 1);
        chk("rst.sm.video_on", von_s, 1); chk("rst.sm.p_tick", pt_s, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state();
        run = 1'b1;
        reset = 1'b0;

        // First tick three edges after release, x steps on the fourth
        at_k(3);
        chk("first.p_tick", pt_d, 1); chk("first.x", x_d, 0); chk("first.sm.p_tick", pt_s, 1);
        at_k(4);
        chk("second.p_tick", pt_d, 0); chk("second.x", x_d, 1); chk("second.sm.x", x_s, 1);

        // Small raster: 24 pixels/line, 12 lines/frame, 1152 clk/frame
        at_k(64);   chk("sm(16,0).video_on", von_s, 0); chk("sm(16,0).x", x_s, 16);
        at_k(540);  chk("sm(15,5).video_on", von_s, 1); chk("sm(15,5).y", y_s, 5);
        at_k(576);  chk("sm(0,6).video_on", von_s, 0); chk("sm(0,6).y", y_s, 6);
        at_k(767);  chk("sm(23,7).vsync", vs_s, 1);
        at_k(768);  chk("sm(0,8).vsync", vs_s, 0);
        at_k(959);  chk("sm(23,9).vsync", vs_s, 0);
        at_k(960);  chk("sm(0,10).vsync", vs_s, 1);
        at_k(1148); chk("sm(23,11).video_on", von_s, 0); chk("sm(23,11).x", x_s, 23);
                    chk("sm(23,11).y", y_s, 11);
        at_k(1152); chk("sm.wrap.x", x_s, 0); chk("sm.wrap.y", y_s, 0);
                    chk("sm.wrap.video_on", von_s, 1);

        // Default raster: hsync low for x in 656..751, one line = 3200 clk
        at_k(2623); chk("def(655).hsync", hs_d, 1); chk("def(655).x", x_d, 655);
        at_k(2624); chk("def(656).hsync", hs_d, 0);
        at_k(3007); chk("def(751).hsync", hs_d, 0);
        at_k(3008); chk("def(752).hsync", hs_d, 1);
        at_k(3199); chk("def(799,0).x", x_d, 799); chk("def(799,0).y", y_d, 0);
        at_k(3200); chk("def(0,1).x", x_d, 0); chk("def(0,1).y", y_d, 1);
                    chk("def(0,1).video_on", von_d, 1);

        // Reset pulse in the middle of the small raster's vsync
        at_k(4300);
        chk("pre_rst.sm.vsync", vs_s, 0);
        #1 reset = 1'b1;
        #1 chk_reset_state();
        @(negedge clk);
        reset = 1'b0;
        at_k(767);  chk("post_rst.sm.vsync_hi", vs_s, 1);
        at_k(768);  chk("post_rst.sm.vsync_lo", vs_s, 0); chk("post_rst.sm.y", y_s, 8);
        at_k(1152); chk("post_rst.sm.wrap.y", y_s, 0); chk("post_rst.sm.wrap.video_on", von_s, 1);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
